bcd_digit_serializer: RTL and testbench



---
 rtl/bcd_digit_serializer.sv | 127 ++++++++++++
 tb/tb_bcd_digit_serializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_serializer.sv
// bcd_digit_serializer
// Captures a packed BCD word and streams its digits, most significant first,
// as ASCII characters over a valid/ready handshake. Words that arrive while a
// previous word is still streaming are dropped and flagged on overrun_flag.
// Optional macro: BCD_DIGIT_SERIALIZER_LEADING_ZERO_SUPPRESS_EN skips leading
// zero digits. At least one character is always emitted.
module bcd_digit_serializer #(
    parameter int Digit_Count = 3,
    parameter int Index_Width = (Digit_Count > 1) ? $clog2(Digit_Count) : 1
) (
    input  logic                     clk,
    input  logic                     clk_en,
    input  logic                     sync_rst,
    input  logic [4*Digit_Count-1:0] bcd_input,
    input  logic                     valid_input,
    output logic                     input_ready,
    output logic [7:0]               digit_output,
    output logic                     digit_valid,
    output logic                     digit_last,
    input  logic                     digit_ready,
    output logic                     overrun_flag,
    input  logic                     clear_overrun
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [4*Digit_Count-1:0] word_q, word_d;
    logic [Index_Width-1:0]   index_q, index_d;
    logic [7:0]               char_q, char_d;
    logic                     last_q, last_d;
    logic                     ovf_q, ovf_d;

    logic [Index_Width-1:0]   start_idx;
    logic                     xfer, capture, overrun;

    // Digits 10..15 are not valid BCD; show them as '?'.
    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

    function automatic logic [3:0] nibble(input logic [4*Digit_Count-1:0] w,
                                          input logic [Index_Width-1:0]   i);
        return w[4*i +: 4];
    endfunction

    // Choose the first digit to emit for the incoming word.
    always_comb begin
`ifdef BCD_DIGIT_SERIALIZER_LEADING_ZERO_SUPPRESS_EN
        // Highest nonzero nibble; an all-zero word still emits digit 0.
        start_idx = '0;
        for (int i = 0; i < Digit_Count; i++) begin
            if (bcd_input[4*i +: 4] != 4'h0) start_idx = Index_Width'(i);
        end
`else
        start_idx = Index_Width'(Digit_Count - 1);
`endif
    end

    // Ready while idle, or in the cycle the final digit leaves so a new word
    // can follow with no bubble.
    always_comb begin
        input_ready = (state_q == ST_IDLE) || ((index_q == '0) && digit_ready);
        xfer        = (state_q == ST_EMIT) && digit_ready && clk_en;
        capture     = valid_input && input_ready && clk_en;
        overrun     = valid_input && !input_ready && clk_en;
    end

    // Next-state: advance on transfer, then a capture overrides the return to idle.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        index_d = index_q;
        char_d  = char_q;
        last_d  = last_q;
        ovf_d   = ovf_q;

        if (xfer) begin
            if (index_q != '0) begin
                index_d = index_q - 1'b1;
                char_d  = to_ascii(nibble(word_q, index_q - 1'b1));
                last_d  = (index_q == Index_Width'(1));
            end else begin
                state_d = ST_IDLE;
                last_d  = 1'b0;
            end
        end

        if (capture) begin
            word_d  = bcd_input;
            index_d = start_idx;
            state_d = ST_EMIT;
            char_d  = to_ascii(nibble(bcd_input, start_idx));
            last_d  = (start_idx == '0);
        end

        // A new drop in the same cycle as a clear keeps the flag set.
        if (overrun)                      ovf_d = 1'b1;
        else if (clear_overrun && clk_en) ovf_d = 1'b0;
    end

    // State registers; reset wins over clk_en, clk_en low freezes everything.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            index_q <= '0;
            char_q  <= 8'h00;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clk_en) begin
            state_q <= state_d;
            word_q  <= word_d;
            index_q <= index_d;
            char_q  <= char_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    assign digit_output = char_q;
    assign digit_valid  = (state_q == ST_EMIT);
    assign digit_last   = last_q;
    assign overrun_flag = ovf_q;

endmodule

// File: tb/tb_bcd_digit_serializer.sv
// Testbench for bcd_digit_serializer (Digit_Count=3).
// A queue model of pending characters is checked against the DUT every
// negative edge; per-scenario literal strings pin both DUT and model streams.
module tb_bcd_digit_serializer;

    localparam int DC = 3;

    logic          clk = 1'b0;
    logic          clk_en, sync_rst, valid_input, digit_ready, clear_overrun;
    logic [4*DC-1:0] bcd_input;
    logic          input_ready, digit_valid, digit_last, overrun_flag;
    logic [7:0]    digit_output;

    always #5 clk = ~clk;

    bcd_digit_serializer #(.Digit_Count(DC)) dut (
        .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst),
        .bcd_input(bcd_input), .valid_input(valid_input), .input_ready(input_ready),
        .digit_output(digit_output), .digit_valid(digit_valid), .digit_last(digit_last),
        .digit_ready(digit_ready), .overrun_flag(overrun_flag), .clear_overrun(clear_overrun)
    );

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [7:0] ch; logic last; } ent_t;
    ent_t  mq[$];
    logic  m_ovf    = 1'b0;
    bit    rst_seen = 1'b0;
    int    cyc      = 0;
    byte   dut_log[$];
    int    dut_t[$];
    byte   mdl_log[$];

    function automatic logic [7:0] ascii_of(input int d);
        return (d < 10) ? 8'(8'h30 + d) : 8'h3F;
    endfunction

    task automatic push_word(input logic [4*DC-1:0] w);
        int d[DC];
        int top;
        ent_t e;
        for (int i = 0; i < DC; i++) d[i] = int'((w >> (4*i)) & 'hF);
`ifdef BCD_DIGIT_SERIALIZER_LEADING_ZERO_SUPPRESS_EN
        top = 0;
        for (int i = 0; i < DC; i++) if (d[i] != 0) top = i;
`else
        top = DC - 1;
`endif
        for (int i = top; i >= 0; i--) begin
            e.ch = ascii_of(d[i]);
            e.last = (i == 0);
            mq.push_back(e);
        end
    endtask

    always @(posedge clk) begin
        bit rdy;
        cyc++;
        if (sync_rst) begin
            mq.delete();
            m_ovf    = 1'b0;
            rst_seen = 1'b1;
        end else if (clk_en && rst_seen) begin
            if (digit_valid && digit_ready) begin
                dut_log.push_back(digit_output);
                dut_t.push_back(cyc);
            end
            rdy = (mq.size() == 0) || (mq.size() == 1 && digit_ready);
            if (mq.size() > 0 && digit_ready) mdl_log.push_back(mq.pop_front().ch);
            if (valid_input && rdy) push_word(bcd_input);
            if (valid_input && !rdy) m_ovf = 1'b1;
            else if (clear_overrun)  m_ovf = 1'b0;
        end
    end

    // Compare process: every cycle once reset has been seen.
    always @(negedge clk) begin
        if (rst_seen) begin
            chk("digit_valid", digit_valid, mq.size() != 0);
            chk("input_ready", input_ready,
                (mq.size() == 0) || (mq.size() == 1 && digit_ready));
            chk("overrun_flag", overrun_flag, m_ovf);
            if (mq.size() != 0) begin
                chk("digit_output", digit_output, mq[0].ch);
                chk("digit_last", digit_last, mq[0].last);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic send(input logic [4*DC-1:0] w);
        bcd_input   = w;
        valid_input = 1'b1;
        tick();
        valid_input = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (mq.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("drain_timeout", mq.size(), 0);
        tick();
    endtask

    task automatic clear_logs();
        dut_log.delete();
        dut_t.delete();
        mdl_log.delete();
    endtask

    task automatic check_log(input string name, input string exp);
        chk({name, "_dut_len"}, dut_log.size(), exp.len());
        chk({name, "_mdl_len"}, mdl_log.size(), exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            if (i < dut_log.size()) chk({name, "_dut_ch"}, dut_log[i], exp[i]);
            if (i < mdl_log.size()) chk({name, "_mdl_ch"}, mdl_log[i], exp[i]);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        clk_en = 1'b0; sync_rst = 1'b1; valid_input = 1'b0;
        digit_ready = 1'b0; clear_overrun = 1'b0; bcd_input = '0;
        tick();
        chk("rst_ready", input_ready, 1'b1);
        chk("rst_valid", digit_valid, 1'b0);
        chk("rst_output", digit_output, 8'h00);
        chk("rst_ovf", overrun_flag, 1'b0);
        sync_rst = 1'b0; clk_en = 1'b1; digit_ready = 1'b1;
        tick();

        // Basic
        clear_logs(); send(12'h255); drain();
        check_log("basic", "255");

        // Suppression patterns
        clear_logs(); send(12'h007); drain();
`ifdef BCD_DIGIT_SERIALIZER_LEADING_ZERO_SUPPRESS_EN
        check_log("sup007", "7");
`else
        check_log("sup007", "007");
`endif
        clear_logs(); send(12'h000); drain();
`ifdef BCD_DIGIT_SERIALIZER_LEADING_ZERO_SUPPRESS_EN
        check_log("sup000", "0");
`else
        check_log("sup000", "000");
`endif
        clear_logs(); send(12'h0A1); drain();
`ifdef BCD_DIGIT_SERIALIZER_LEADING_ZERO_SUPPRESS_EN
        check_log("sup0A1", "?1");
`else
        check_log("sup0A1", "0?1");
`endif

        // Backpressure with a dropped word during the stall
        clear_logs(); send(12'h482);
        digit_ready = 1'b0;
        tick();
        chk("stall_hold", digit_output, 8'h34);
        send(12'h999);
        chk("stall_hold2", digit_output, 8'h34);
        chk("ovf_set", overrun_flag, 1'b1);
        digit_ready = 1'b1;
        drain();
        check_log("bp", "482");
        clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
        chk("ovf_clr", overrun_flag, 1'b0);

        // Back-to-back with no bubble
        clear_logs(); send(12'h123);
        tick(); tick();
        send(12'h456);
        drain();
        check_log("b2b", "123456");
        for (int i = 0; i + 1 < dut_t.size(); i++)
            chk("b2b_gap", dut_t[i+1] - dut_t[i], 1);
        chk("b2b_ovf", overrun_flag, 1'b0);

        // clk_en freeze mid-word
        clear_logs(); send(12'h255);
        tick();
        clk_en = 1'b0;
        tick(); tick(); tick();
        chk("freeze_out", digit_output, 8'h35);
        clk_en = 1'b1;
        drain();
        check_log("freeze", "255");

        // Reset after the first character
        clear_logs(); send(12'h999);
        tick();
        sync_rst = 1'b1; tick(); sync_rst = 1'b0;
        chk("rst_mid_valid", digit_valid, 1'b0);
        tick(); tick(); tick();
        check_log("rstmid", "9");
        chk("rst_mid_idle", digit_valid, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
